// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage 16-bit SRAM controller.
package sram_ctrl_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
    localparam int unsigned SRAM_AW       = 18;
    localparam int unsigned SRAM_DW       = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that times how long each half access is held on the SRAM pins.
module sram_wait_counter #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);

    localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACCESS_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller splitting 32-bit loads/stores into two 16-bit SRAM half accesses.
// Optional stall-cycle counter output enabled by defining SRAM_CTRL_STALL_CNT_EN.
module mem_stage_sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [31:0]          address,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    output logic                 ready,
    output logic [SRAM_AW-1:0]   sram_addr,
    output logic [SRAM_DW-1:0]   sram_dq_out,
    input  logic [SRAM_DW-1:0]   sram_dq_in,
    output logic                 sram_dq_oe,
    output logic                 sram_we_n
`ifdef SRAM_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);

    state_t                state_q, state_d;
    logic                  op_wr_q, op_wr_d;
    logic [SRAM_AW-2:0]    idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [SRAM_AW-1:0]    addr_q, addr_d;
    logic [SRAM_DW-1:0]    dq_q, dq_d;
    logic                  oe_q, oe_d;
    logic                  we_n_q, we_n_d;

    logic                  req;
    logic                  cnt_load;
    logic                  cnt_last;
    logic [31:0]           offset;
    logic [SRAM_AW-2:0]    req_idx;
    logic                  unused_offset_bits;

    assign req     = rd_en | wr_en;
    // Subtraction wraps mod 2^32; addresses below BASE_ADDR simply alias.
    assign offset  = address - BASE_ADDR;
    assign req_idx = offset[SRAM_AW:2];
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    sram_wait_counter #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .last (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        op_wr_d  = op_wr_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        dq_d     = dq_q;
        oe_d     = oe_q;
        we_n_d   = we_n_q;
        cnt_load = 1'b0;
        ready    = 1'b0;

        case (state_q)
            IDLE: begin
                ready = !req;
                if (req) begin
                    op_wr_d  = wr_en;
                    idx_d    = req_idx;
                    wdata_d  = write_data;
                    addr_d   = {req_idx, 1'b0};
                    if (wr_en) begin
                        dq_d   = write_data[15:0];
                        oe_d   = 1'b1;
                        we_n_d = 1'b0;
                    end
                    cnt_load = 1'b1;
                    state_d  = LO;
                end
            end
            LO: begin
                if (cnt_last) begin
                    if (!op_wr_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                    addr_d   = {idx_q, 1'b1};
                    dq_d     = wdata_q[31:16];
                    cnt_load = 1'b1;
                    state_d  = HI;
                end
            end
            HI: begin
                if (cnt_last) begin
                    if (!op_wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                    oe_d    = 1'b0;
                    we_n_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            dq_q    <= '0;
            oe_q    <= 1'b0;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            oe_q    <= oe_d;
            we_n_q  <= we_n_d;
        end
    end

    assign read_data   = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_q;
    assign sram_dq_oe  = oe_q;
    assign sram_we_n   = we_n_q;

`ifdef SRAM_CTRL_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!ready) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Randomized self-checking bench for mem_stage_sram_ctrl against a cycle-offset reference model.
module tb_mem_stage_sram_ctrl;

    localparam int          AC   = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;
`ifdef SRAM_CTRL_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    logic [15:0] mem [0:1023];
    assign sram_dq_in = mem[sram_addr[9:0]];

    mem_stage_sram_ctrl #(
        .BASE_ADDR    (BASE),
        .ACCESS_CYCLES(AC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
`ifdef SRAM_CTRL_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    // Reference model: position of the current access relative to its request cycle
    int          r;
    logic        m_wr;
    logic [16:0] m_idx;
    logic [31:0] m_wd;
    logic [17:0] e_addr;
    logic [15:0] e_dq;
    logic        e_oe;
    logic        e_we_n;
    logic [31:0] e_rd;
    logic [31:0] e_stall;
    logic        last_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        r       = -1;
        m_wr    = 1'b0;
        m_idx   = '0;
        m_wd    = '0;
        e_addr  = '0;
        e_dq    = '0;
        e_oe    = 1'b0;
        e_we_n  = 1'b1;
        e_rd    = '0;
        e_stall = '0;
    endtask

    task automatic model_cycle();
        logic        e_ready;
        logic [31:0] off;
        logic        half;
        logic [17:0] a;
        if (r < 0 && (rd_en || wr_en)) begin
            r     = 0;
            m_wr  = wr_en;
            off   = address - BASE;
            m_idx = off[18:2];
            m_wd  = write_data;
        end
        e_ready = (r < 0) || (r == 2*AC+1);
        if (r >= 1 && r <= 2*AC) begin
            half   = (r > AC);
            e_addr = {m_idx, half};
            e_oe   = m_wr;
            e_we_n = !m_wr;
            if (m_wr || half) e_dq = half ? m_wd[31:16] : m_wd[15:0];
        end
        if (r == 2*AC+1) begin
            e_oe   = 1'b0;
            e_we_n = 1'b1;
        end
        if (!m_wr && r == AC+1) begin
            a = {m_idx, 1'b0};
            e_rd[15:0] = mem[a[9:0]];
        end
        if (!m_wr && r == 2*AC+1) begin
            a = {m_idx, 1'b1};
            e_rd[31:16] = mem[a[9:0]];
        end
        chk("ready", 32'(ready), 32'(e_ready));
        chk("sram_addr", 32'(sram_addr), 32'(e_addr));
        chk("sram_dq_out", 32'(sram_dq_out), 32'(e_dq));
        chk("sram_dq_oe", 32'(sram_dq_oe), 32'(e_oe));
        chk("sram_we_n", 32'(sram_we_n), 32'(e_we_n));
        chk("read_data", read_data, e_rd);
`ifdef SRAM_CTRL_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, e_stall);
`endif
        if (!e_ready) e_stall = e_stall + 32'd1;
        if (r >= 0) begin
            r++;
            if (r > 2*AC+1) r = -1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        last_ready = ready;
        if (!sram_we_n) mem[sram_addr[9:0]] = sram_dq_out;
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        rd_en      = rd;
        wr_en      = wr;
        address    = a;
        write_data = d;
        step();
        rd_en = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < 2*AC+1; i++) step();
    endtask

    initial begin
        logic [31:0] saved;
        int          hi_cnt;
        n_chk      = 0;
        n_err      = 0;
        last_ready = 1'b0;
        rst        = 1'b1;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = '0;
        write_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        model_reset();

        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Directed write and read-back of the same word
        do_access(1'b0, 1'b1, BASE + 32'd8, 32'hDEAD_BEEF);
        chk("wr_mem_lo", 32'(mem[4]), 32'h0000_BEEF);
        chk("wr_mem_hi", 32'(mem[5]), 32'h0000_DEAD);
        do_access(1'b1, 1'b0, 32'd1032, 32'h0BAD_F00D);
        chk("rd_word", read_data, 32'hDEAD_BEEF);

        // Both enables: store wins, read_data untouched
        saved = read_data;
        do_access(1'b1, 1'b1, 32'd1036, 32'h1234_5678);
        chk("both_rdata_hold", read_data, saved);
        chk("both_mem_lo", 32'(mem[6]), 32'h0000_5678);
        chk("both_mem_hi", 32'(mem[7]), 32'h0000_1234);

        // Back-to-back loads with rd_en held through DONE
        rd_en   = 1'b1;
        address = 32'd1032;
        hi_cnt  = 0;
        for (int i = 0; i < 2*(2*AC+2)-1; i++) begin
            step();
            if (last_ready) hi_cnt++;
        end
        chk("b2b_ready_gap", 32'(hi_cnt), 32'd1);
        rd_en = 1'b0;
        for (int i = 0; i < 2*AC+2 && r >= 0; i++) step();

        // Reset asserted in the upper half of a store
        wr_en      = 1'b1;
        address    = 32'd1040;
        write_data = 32'hCAFE_0123;
        step();
        wr_en = 1'b0;
        for (int i = 0; i < AC; i++) step();
        rst = 1'b1;
        #1;
        chk("midrst_we_n", 32'(sram_we_n), 32'd1);
        chk("midrst_oe", 32'(sram_dq_oe), 32'd0);
        chk("midrst_read_data", read_data, 32'd0);
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_mem_hi", 32'(mem[9]) == 32'h0000_CAFE ? 32'd1 : 32'd0, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        for (int k = 0; k < 3; k++) begin
            do_access(1'($urandom), 1'($urandom), BASE + 32'(4 * $urandom_range(0, 255)), $urandom);
        end
`ifdef SRAM_CTRL_STALL_CNT_EN
        chk("stall_three", stall_cycles, 32'd15);
`endif

        // Random traffic, including requests that change or drop mid-access
        for (int i = 0; i < 400; i++) begin
            rd_en = ($urandom_range(0, 3) == 0);
            wr_en = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) address = $urandom;
            else address = BASE + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(0, 3));
            write_data = $urandom;
            step();
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < 2*AC+3; i++) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
